// File: rtl/rd_readout_sequencer_pkg.sv
// Shared RD interface definitions: status word layout, result codes and
// the readout sequencer state encoding.
package rd_readout_sequencer_pkg;

  // One bit per buffer (0..3) inside each 4-bit status field
  localparam int RD_BUF_FULL_SHIFT = 0;
  localparam int RD_BUF_BUSY_SHIFT = 4;
  localparam int RD_PARITY0_SHIFT  = 8;
  localparam int RD_PARITY1_SHIFT  = 12;
  localparam int RD_BUF_RNUM_SHIFT = 16;

  localparam logic [1:0] RES_OK           = 2'd0;
  localparam logic [1:0] RES_NO_DATA      = 2'd1;
  localparam logic [1:0] RES_BUSY_TIMEOUT = 2'd2;
  localparam logic [1:0] RES_PARITY       = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT,
    ST_REQ,
    ST_XFR,
    ST_CLR_RD,
    ST_REL_WCD,
    ST_FIN
  } rd_seq_state_e;

  function automatic logic [3:0] status_field(input logic [31:0] status, input int shift);
    return status[shift +: 4];
  endfunction

endpackage

// File: rtl/rd_wait_timer.sv
// Loadable down-counter that saturates at zero; shared by RD watchdogs.
module rd_wait_timer #(
  parameter int DATA_W = 15
) (
  input  logic              CLK120,
  input  logic              RST,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              dec,
  output logic [DATA_W-1:0] count,
  output logic              zero
);

  always_ff @(posedge CLK120) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - DATA_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rd_readout_sequencer.sv
// Reads out one RD event buffer: status check, bounded busy wait, DMA burst,
// RD full-flag clear and WCD buffer release.
module rd_readout_sequencer
  import rd_readout_sequencer_pkg::*;
#(
  parameter int BUSY_WAIT_CYCLES = 24000,
  parameter int XFR_WORDS        = 2048,
  parameter int BUF_ADDR_BITS    = 13
) (
  input  logic        CLK120,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  BUF_RNUM,
  input  logic [31:0] RD_STATUS,
  output logic [31:0] RD_CONTROL,
  output logic        RD_CONTROL_WRITTEN,
  output logic        XFR_REQ,
  output logic [14:0] XFR_ADDR,
  output logic [11:0] XFR_LEN,
  input  logic        XFR_ACK,
  input  logic        XFR_DONE,
  output logic        WCD_RELEASE,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:0]  RESULT
);

  localparam int TIMER_W = $clog2(BUSY_WAIT_CYCLES);

  rd_seq_state_e      state_r, state_nxt;
  logic [1:0]         buf_r, buf_nxt;
  logic [1:0]         result_r, result_nxt;
  logic [1:0]         ctrl_r, ctrl_nxt;
  logic               perr_r, perr_nxt;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0] tmr_count_unused;
  logic [3:0]         full_v, busy_v, par0_v, par1_v;
  logic               full_sel, busy_sel, par_sel;
  logic               unused_status;

  assign full_v   = status_field(RD_STATUS, RD_BUF_FULL_SHIFT);
  assign busy_v   = status_field(RD_STATUS, RD_BUF_BUSY_SHIFT);
  assign par0_v   = status_field(RD_STATUS, RD_PARITY0_SHIFT);
  assign par1_v   = status_field(RD_STATUS, RD_PARITY1_SHIFT);
  assign full_sel = full_v[buf_r];
  assign busy_sel = busy_v[buf_r];
  assign par_sel  = par0_v[buf_r] | par1_v[buf_r];
  assign unused_status = ^RD_STATUS[31:16];

  rd_wait_timer #(.DATA_W(TIMER_W)) u_wait_timer (
    .CLK120   (CLK120),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (TIMER_W'(BUSY_WAIT_CYCLES - 1)),
    .dec      (tmr_dec),
    .count    (tmr_count_unused),
    .zero     (tmr_zero)
  );

  always_ff @(posedge CLK120) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      buf_r    <= '0;
      result_r <= RES_OK;
      ctrl_r   <= '0;
      perr_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      buf_r    <= buf_nxt;
      result_r <= result_nxt;
      ctrl_r   <= ctrl_nxt;
      perr_r   <= perr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_r;
    buf_nxt    = buf_r;
    result_nxt = result_r;
    ctrl_nxt   = ctrl_r;
    perr_nxt   = perr_r;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          buf_nxt    = BUF_RNUM;
          result_nxt = RES_OK;
          perr_nxt   = 1'b0;
          state_nxt  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (full_sel) begin
          perr_nxt  = par_sel;
          state_nxt = ST_REQ;
        end else if (busy_sel) begin
          tmr_load  = 1'b1;
          state_nxt = ST_WAIT;
        end else begin
          result_nxt = RES_NO_DATA;
          state_nxt  = ST_REL_WCD;
        end
      end
      // FULL takes priority over an expiring timer in the same cycle
      ST_WAIT: begin
        if (full_sel) begin
          perr_nxt  = par_sel;
          state_nxt = ST_REQ;
        end else if (tmr_zero) begin
          result_nxt = RES_BUSY_TIMEOUT;
          ctrl_nxt   = buf_r;
          state_nxt  = ST_CLR_RD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_REQ: begin
        if (XFR_ACK) begin
          if (XFR_DONE) begin
            result_nxt = perr_r ? RES_PARITY : RES_OK;
            ctrl_nxt   = buf_r;
            state_nxt  = ST_CLR_RD;
          end else begin
            state_nxt = ST_XFR;
          end
        end
      end
      ST_XFR: begin
        if (XFR_DONE) begin
          result_nxt = perr_r ? RES_PARITY : RES_OK;
          ctrl_nxt   = buf_r;
          state_nxt  = ST_CLR_RD;
        end
      end
      ST_CLR_RD:  state_nxt = ST_REL_WCD;
      ST_REL_WCD: state_nxt = ST_FIN;
      ST_FIN:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign BUSY               = (state_r != ST_IDLE);
  assign XFR_REQ            = (state_r == ST_REQ);
  assign XFR_ADDR           = XFR_REQ ? (15'(buf_r) << BUF_ADDR_BITS) : '0;
  assign XFR_LEN            = XFR_REQ ? 12'(XFR_WORDS - 1) : '0;
  assign RD_CONTROL         = {30'b0, ctrl_r};
  assign RD_CONTROL_WRITTEN = (state_r == ST_CLR_RD);
  assign WCD_RELEASE        = (state_r == ST_REL_WCD);
  assign DONE               = (state_r == ST_FIN);
  assign RESULT             = result_r;

endmodule
